param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 134 +++++++++++++
 tb/tb_param_sync_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with a block-RAM style store, registered status flags,
// sticky overflow/underflow, and a selectable standard or first-word-fall-through read port.
module param_sync_fifo #(
   parameter int DATA_W = 128,
   parameter int DEPTH  = 1024,
   parameter int AF_TH  = 4,
   parameter int AE_TH  = 2,
   parameter int FWFT   = 0
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       i_wren,
   input  logic [DATA_W-1:0]          i_wrdata,
   input  logic                       i_rden,
   input  logic                       i_clr_err,
   output logic [DATA_W-1:0]          o_rddata,
   output logic                       o_rdvalid,
   output logic                       o_full,
   output logic                       o_empty,
   output logic                       o_alm_full,
   output logic                       o_alm_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_overflow,
   output logic                       o_underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_TH);
   localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_TH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              alm_full_q, alm_full_d;
   logic              alm_empty_q, alm_empty_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic              rdvalid_q, rdvalid_d;
   logic              byp_sel_q, byp_sel_d;
   logic [DATA_W-1:0] byp_data_q, byp_data_d;

   logic              wr_acc;
   logic              rd_acc;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;

   always_comb begin
      wr_acc      = i_wren && !full_q;
      rd_acc      = i_rden && !empty_q;
      wr_ptr_d    = wr_ptr_q + ADDR_W'(wr_acc);
      rd_ptr_d    = rd_ptr_q + ADDR_W'(rd_acc);
      count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
      full_d      = (count_d == DEPTH_C);
      empty_d     = (count_d == '0);
      alm_full_d  = ((DEPTH_C - count_d) <= AF_C);
      alm_empty_d = (count_d <= AE_C);
      // A same-cycle error event wins over the clear.
      ovf_d       = (i_wren && full_q) || (ovf_q && !i_clr_err);
      udf_d       = (i_rden && empty_q) || (udf_q && !i_clr_err);
      rdvalid_d   = rd_acc;
      byp_data_d  = i_wrdata;
      if (FWFT != 0) begin
         // Prefetch the next head every cycle; when that head is the word being
         // written right now the RAM still holds stale data, so forward it instead.
         ram_addr  = rd_ptr_d;
         ram_re    = 1'b1;
         byp_sel_d = wr_acc && (rd_ptr_d == wr_ptr_q);
      end else begin
         ram_addr  = rd_ptr_q;
         ram_re    = rd_acc;
         byp_sel_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rstn && wr_acc)
         mem_q[wr_ptr_q] <= i_wrdata;
   end

   always_ff @(posedge clk) begin
      if (!rstn)
         rd_data_q <= '0;
      else if (ram_re)
         rd_data_q <= mem_q[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         alm_full_q  <= 1'b0;
         alm_empty_q <= 1'b1;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         rdvalid_q   <= 1'b0;
         byp_sel_q   <= 1'b0;
         byp_data_q  <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         full_q      <= full_d;
         empty_q     <= empty_d;
         alm_full_q  <= alm_full_d;
         alm_empty_q <= alm_empty_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         rdvalid_q   <= rdvalid_d;
         byp_sel_q   <= byp_sel_d;
         byp_data_q  <= byp_data_d;
      end
   end

   assign o_rddata    = byp_sel_q ? byp_data_q : rd_data_q;
   assign o_rdvalid   = (FWFT != 0) ? !empty_q : rdvalid_q;
   assign o_full      = full_q;
   assign o_empty     = empty_q;
   assign o_alm_full  = alm_full_q;
   assign o_alm_empty = alm_empty_q;
   assign o_count     = count_q;
   assign o_overflow  = ovf_q;
   assign o_underflow = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: one standard-mode and one FWFT instance share the same
// stimulus (DEPTH=16, DATA_W=8); expected values are hand-derived constants.
module tb_param_sync_fifo;

   logic       clk = 1'b0;
   logic       rstn;
   logic       i_wren, i_rden, i_clr_err;
   logic [7:0] i_wrdata;

   logic [7:0] s_rddata, f_rddata;
   logic       s_rdvalid, f_rdvalid;
   logic       s_full, f_full, s_empty, f_empty;
   logic       s_alm_full, f_alm_full, s_alm_empty, f_alm_empty;
   logic [4:0] s_count, f_count;
   logic       s_ovf, f_ovf, s_udf, f_udf;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_TH(4), .AE_TH(2), .FWFT(0)) u_std (
      .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
      .i_clr_err(i_clr_err), .o_rddata(s_rddata), .o_rdvalid(s_rdvalid), .o_full(s_full),
      .o_empty(s_empty), .o_alm_full(s_alm_full), .o_alm_empty(s_alm_empty),
      .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
   );

   param_sync_fifo #(.DATA_W(8), .DEPTH(16), .AF_TH(4), .AE_TH(2), .FWFT(1)) u_fwft (
      .clk(clk), .rstn(rstn), .i_wren(i_wren), .i_wrdata(i_wrdata), .i_rden(i_rden),
      .i_clr_err(i_clr_err), .o_rddata(f_rddata), .o_rdvalid(f_rdvalid), .o_full(f_full),
      .o_empty(f_empty), .o_alm_full(f_alm_full), .o_alm_empty(f_alm_empty),
      .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      else begin
         n_pass++;
         $display("ok   %s = 0x%0h", tag, got);
      end
   endtask

   // Inputs change on the falling edge, outputs are sampled on the next one.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] d);
      i_wren   = 1'b1;
      i_wrdata = d;
      step();
      i_wren   = 1'b0;
   endtask

   task automatic rd();
      i_rden = 1'b1;
      step();
      i_rden = 1'b0;
   endtask

   task automatic chk_reset(input string p);
      check({p, "_count"},     s_count, 0);
      check({p, "_empty"},     s_empty, 1);
      check({p, "_alm_empty"}, s_alm_empty, 1);
      check({p, "_full"},      s_full, 0);
      check({p, "_alm_full"},  s_alm_full, 0);
      check({p, "_rdvalid"},   s_rdvalid, 0);
      check({p, "_rddata"},    s_rddata, 0);
      check({p, "_ovf"},       s_ovf, 0);
      check({p, "_udf"},       s_udf, 0);
      check({p, "_f_rdvalid"}, f_rdvalid, 0);
      check({p, "_f_rddata"},  f_rddata, 0);
      check({p, "_f_count"},   f_count, 0);
   endtask

   initial begin
      rstn = 1'b0; i_wren = 1'b0; i_rden = 1'b0; i_clr_err = 1'b0; i_wrdata = '0;
      @(negedge clk);
      step();
      step();
      rstn = 1'b1;
      chk_reset("rst");

      // Fill 0x01..0x10, watch thresholds, then overflow and ordered drain.
      for (int k = 1; k <= 16; k++) begin
         wr(8'(k));
         check("fill_count", s_count, k);
         check("fill_alm_full", s_alm_full, (k >= 12));
         check("fill_alm_empty", s_alm_empty, (k <= 2));
      end
      check("fill_full", s_full, 1);
      check("fill_f_head", f_rddata, 8'h01);
      wr(8'h11);
      check("ovf_set", s_ovf, 1);
      check("ovf_f_set", f_ovf, 1);
      check("ovf_count", s_count, 16);
      i_rden = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         check("drain_data", s_rddata, k);
         check("drain_valid", s_rdvalid, 1);
         if (k < 16) check("drain_f_head", f_rddata, k + 1);
         check("drain_f_valid", f_rdvalid, (k < 16));
      end
      i_rden = 1'b0;
      check("drain_empty", s_empty, 1);
      check("drain_count", s_count, 0);
      check("drain_udf", s_udf, 0);
      step();
      check("idle_rdvalid", s_rdvalid, 0);
      check("idle_hold", s_rddata, 8'h10);

      // Standard-mode single word and underflow.
      i_clr_err = 1'b1;
      step();
      i_clr_err = 1'b0;
      check("clr_ovf", s_ovf, 0);
      wr(8'hA5);
      check("a5_f_data", f_rddata, 8'hA5);
      check("a5_f_valid", f_rdvalid, 1);
      rd();
      check("a5_data", s_rddata, 8'hA5);
      check("a5_valid", s_rdvalid, 1);
      rd();
      check("udf_set", s_udf, 1);
      check("udf_rdvalid", s_rdvalid, 0);
      check("udf_hold", s_rddata, 8'hA5);
      i_clr_err = 1'b1;
      step();
      i_clr_err = 1'b0;
      check("clr_udf", s_udf, 0);

      // FWFT head visibility before any read.
      wr(8'h3C);
      check("fw_data", f_rddata, 8'h3C);
      check("fw_valid", f_rdvalid, 1);
      check("fw_not_empty", f_empty, 0);
      rd();
      check("fw_pop_empty", f_empty, 1);
      check("fw_pop_valid", f_rdvalid, 0);
      check("fw_std_data", s_rddata, 8'h3C);

      // Eight entries, then 20 cycles of write+read through the pointer wrap.
      for (int k = 0; k < 8; k++) wr(8'(8'h40 + k));
      check("mid_count", s_count, 8);
      i_wren = 1'b1;
      i_rden = 1'b1;
      for (int k = 0; k < 20; k++) begin
         i_wrdata = 8'(8'h48 + k);
         step();
         check("wrap_data", s_rddata, 8'h40 + k);
         check("wrap_count", s_count, 8);
         check("wrap_f_head", f_rddata, 8'h41 + k);
      end
      i_wren = 1'b0;
      i_rden = 1'b0;

      // Full with simultaneous write+read; then clear and set-over-clear.
      for (int k = 0; k < 8; k++) wr(8'(8'h60 + k));
      check("e_full", s_full, 1);
      check("e_alm_full", s_alm_full, 1);
      i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 8'hEE;
      step();
      i_wren = 1'b0; i_rden = 1'b0;
      check("e_count", s_count, 15);
      check("e_ovf", s_ovf, 1);
      check("e_data", s_rddata, 8'h54);
      check("e_not_full", s_full, 0);
      i_clr_err = 1'b1;
      step();
      check("e_clr", s_ovf, 0);
      i_clr_err = 1'b0;
      wr(8'h68);
      check("e_refull", s_full, 1);
      i_wren = 1'b1; i_clr_err = 1'b1; i_wrdata = 8'hEF;
      step();
      i_wren = 1'b0;
      check("e_set_wins", s_ovf, 1);
      check("e_rej_count", s_count, 16);
      step();
      i_clr_err = 1'b0;
      check("e_clr2", s_ovf, 0);

      // Drain to 5 entries, reset mid-operation, then one word round trip.
      i_rden = 1'b1;
      repeat (11) step();
      i_rden = 1'b0;
      check("f_count5", s_count, 5);
      check("f_last", s_rddata, 8'h63);
      rstn = 1'b0; i_wren = 1'b1; i_rden = 1'b1; i_wrdata = 8'h99;
      step();
      rstn = 1'b1; i_wren = 1'b0; i_rden = 1'b0;
      chk_reset("mid_rst");
      wr(8'h77);
      check("post_f_data", f_rddata, 8'h77);
      check("post_f_valid", f_rdvalid, 1);
      rd();
      check("post_data", s_rddata, 8'h77);
      check("post_valid", s_rdvalid, 1);
      check("post_empty", s_empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
